colpar_ctrl: RTL and testbench

Sequencing controller for the column-parity datapath (`ColparDP`). Accepts a start request, walks all 64 depth slices and all 25 lanes per slice by driving the datapath's load, enable and counter-control strobes, and signals completion. It sits beside the datapath in the column-parity top level, and its outputs connect one-to-one to the datapath control inputs.

---
 rtl/colpar_pkg.sv | 72 +++++++
 rtl/colpar_ctrl.sv | 108 ++++++++++
 tb/tb_colpar_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/colpar_pkg.sv
// Shared definitions for the column-parity controller: loop sizes, FSM state
// encoding and the control-strobe bundle driven towards the datapath.
package colpar_pkg;

    localparam int unsigned COLPAR_DEPTHS           = 64;
    localparam int unsigned COLPAR_LANES            = 25;
    // One LOAD, one CALC per lane, one NEXT.
    localparam int unsigned COLPAR_CYCLES_PER_DEPTH = 27;
    localparam int unsigned COLPAR_STATE_W          = 3;

    typedef enum logic [COLPAR_STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_LOAD = 3'd2,
        ST_CALC = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } colpar_state_t;

    // Control outputs of the sequencer, one bit per datapath control input.
    typedef struct packed {
        logic ld_fr;
        logic ld_r;
        logic en_fw;
        logic init0_c64;
        logic init0_c25;
        logic en_c64;
        logic en_c25;
        logic ready;
        logic busy;
        logic done;
    } colpar_ctrl_out_t;

    // Moore decode: the control bundle asserted while resident in a state.
    function automatic colpar_ctrl_out_t colpar_decode(input colpar_state_t st);
        colpar_ctrl_out_t o;
        o = '0;
        case (st)
            ST_IDLE: begin
                o.ready = 1'b1;
            end
            ST_INIT: begin
                o.busy      = 1'b1;
                o.init0_c64 = 1'b1;
                o.init0_c25 = 1'b1;
            end
            ST_LOAD: begin
                o.busy  = 1'b1;
                o.ld_fr = 1'b1;
            end
            ST_CALC: begin
                o.busy   = 1'b1;
                o.en_fw  = 1'b1;
                o.en_c25 = 1'b1;
            end
            ST_NEXT: begin
                o.busy   = 1'b1;
                o.ld_r   = 1'b1;
                o.en_c64 = 1'b1;
            end
            ST_DONE: begin
                o.busy = 1'b1;
                o.done = 1'b1;
            end
            default: begin
                o.ready = 1'b1;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/colpar_ctrl.sv
// Sequencer for the column-parity datapath: walks 64 depth slices of 25 lanes
// each, driving counter control, file-reader/writer and previous-depth strobes.
// Optional feature macro: COLPAR_CTRL_STALL_EN adds a stall input that freezes
// the walk in LOAD/CALC/NEXT and blanks all strobes while asserted.
module colpar_ctrl
    import colpar_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic co_c64,
    input  logic co_c25,
`ifdef COLPAR_CTRL_STALL_EN
    input  logic stall,
`endif
    output logic ld_fr,
    output logic ld_r,
    output logic en_fw,
    output logic init0_c64,
    output logic init0_c25,
    output logic en_c64,
    output logic en_c25,
    output logic ready,
    output logic busy,
    output logic done
);

    colpar_state_t    state_q;
    colpar_state_t    state_d;
    colpar_ctrl_out_t out_q;
    colpar_ctrl_out_t out_d;
    logic             walk_c;
    logic             hold_c;

    // States in which the datapath is actively being stepped.
    assign walk_c = (state_q == ST_LOAD) || (state_q == ST_CALC) || (state_q == ST_NEXT);

`ifdef COLPAR_CTRL_STALL_EN
    assign hold_c = stall & walk_c;
`else
    assign hold_c = 1'b0;
`endif

    // Next-state decode; counter carry-outs only matter in CALC/NEXT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!hold_c) begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (!hold_c && co_c25) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (!hold_c) begin
                    state_d = co_c64 ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output bundle for the upcoming state, so the registered copy lines up with state_q.
    always_comb begin
        out_d = colpar_decode(state_d);
    end

    // State and output registers with synchronous reset back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_q   <= colpar_decode(ST_IDLE);
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // Strobes are blanked during a stall; status flags pass straight through.
    assign ld_fr     = out_q.ld_fr     & ~hold_c;
    assign ld_r      = out_q.ld_r      & ~hold_c;
    assign en_fw     = out_q.en_fw     & ~hold_c;
    assign init0_c64 = out_q.init0_c64 & ~hold_c;
    assign init0_c25 = out_q.init0_c25 & ~hold_c;
    assign en_c64    = out_q.en_c64    & ~hold_c;
    assign en_c25    = out_q.en_c25    & ~hold_c;
    assign ready     = out_q.ready;
    assign busy      = out_q.busy;
    assign done      = out_q.done;

endmodule

// File: tb/tb_colpar_ctrl.sv
// Bench for colpar_ctrl: job timeline model derived from cycle arithmetic,
// modelled datapath counters, per-cycle output scoreboard and done-cycle queue.
module tb_colpar_ctrl;

`ifdef COLPAR_CTRL_STALL_EN
    localparam bit HAS_STALL = 1'b1;
`else
    localparam bit HAS_STALL = 1'b0;
`endif

    localparam int DEPTHS   = 64;
    localparam int LANES    = 25;
    localparam int PER_D    = LANES + 2;
    localparam int JOB_LAST = 1 + DEPTHS * PER_D;   // last NEXT cycle (1729)
    localparam int DONE_T   = JOB_LAST + 1;         // done cycle (1730)

    // Output vector bit positions.
    localparam int B_LD_FR = 9, B_LD_R = 8, B_EN_FW = 7, B_I64 = 6, B_I25 = 5;
    localparam int B_EN64 = 4, B_EN25 = 3, B_READY = 2, B_BUSY = 1, B_DONE = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stall_i = 1'b0;
    logic co_c64, co_c25;
    logic ld_fr, ld_r, en_fw, init0_c64, init0_c25, en_c64, en_c25, ready, busy, done;

    logic [4:0] c25;
    logic [5:0] c64;

    int n_vec = 0;
    int n_err = 0;
    int cur_cyc = -1;
    int m_t = -1;
    bit m_known = 1'b0;

    logic [9:0] exp_q[$];
    int         done_q[$];

    always #5 clk = ~clk;

    colpar_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .co_c64    (co_c64),
        .co_c25    (co_c25),
`ifdef COLPAR_CTRL_STALL_EN
        .stall     (stall_i),
`endif
        .ld_fr     (ld_fr),
        .ld_r      (ld_r),
        .en_fw     (en_fw),
        .init0_c64 (init0_c64),
        .init0_c25 (init0_c25),
        .en_c64    (en_c64),
        .en_c25    (en_c25),
        .ready     (ready),
        .busy      (busy),
        .done      (done)
    );

    // Datapath counter model: lane 0..24 and depth 0..63, wrapping at terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            c25 <= '0;
            c64 <= '0;
        end else begin
            if (init0_c25)      c25 <= '0;
            else if (en_c25)    c25 <= (c25 == 5'(LANES - 1)) ? 5'd0 : c25 + 5'd1;
            if (init0_c64)      c64 <= '0;
            else if (en_c64)    c64 <= (c64 == 6'(DEPTHS - 1)) ? 6'd0 : c64 + 6'd1;
        end
    end
    assign co_c25 = (c25 == 5'(LANES - 1));
    assign co_c64 = (c64 == 6'(DEPTHS - 1));

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cur_cyc, act, exp);
        end
    endtask

    // Expected outputs at job-relative cycle t (t<0 means idle).
    function automatic logic [9:0] model_out(input int t, input bit stl);
        logic [9:0] v;
        int         p;
        bit         hold;
        v    = '0;
        hold = HAS_STALL && stl && (t >= 2) && (t <= JOB_LAST);
        if (t < 0) begin
            v[B_READY] = 1'b1;
        end else begin
            v[B_BUSY] = 1'b1;
            if (t == 1) begin
                v[B_I64] = 1'b1;
                v[B_I25] = 1'b1;
            end else if (t == DONE_T) begin
                v[B_DONE] = 1'b1;
            end else if (!hold) begin
                p = (t - 2) % PER_D;
                if (p == 0) begin
                    v[B_LD_FR] = 1'b1;
                end else if (p <= LANES) begin
                    v[B_EN_FW] = 1'b1;
                    v[B_EN25]  = 1'b1;
                end else begin
                    v[B_LD_R] = 1'b1;
                    v[B_EN64] = 1'b1;
                end
            end
        end
        return v;
    endfunction

    // Drive one cycle of inputs, queue the expected outputs, advance the model.
    task automatic cycle(input bit s, input bit r, input bit stl);
        bit hold;
        @(negedge clk);
        cur_cyc++;
        start   = s;
        rst     = r;
        stall_i = stl;
        if (m_known) exp_q.push_back(model_out(m_t, stl));
        hold = HAS_STALL && stl && (m_t >= 2) && (m_t <= JOB_LAST);
        if (r) begin
            m_t     = -1;
            m_known = 1'b1;
        end else if (m_known) begin
            if (m_t < 0)              m_t = s ? 1 : -1;
            else if (m_t == DONE_T)   m_t = -1;
            else if (!hold)           m_t = m_t + 1;
        end
    endtask

    // One job from an idle controller, with optional re-start, abort and stall window.
    task automatic run_job(input int reassert_at, input int abort_at,
                           input int stall_at, input int stall_len, input int extra);
        int  c0;
        int  total;
        int  len_eff;
        bit  stl;
        int  lane_before;
        len_eff = HAS_STALL ? stall_len : 0;
        cycle(1'b1, 1'b0, 1'b0);
        c0 = cur_cyc;
        if (abort_at < 0) begin
            done_q.push_back(c0 + DONE_T + len_eff);
            total = DONE_T + 1 + len_eff + extra;
        end else begin
            total = abort_at + 3;
        end
        lane_before = 0;
        for (int rel = 1; rel <= total; rel++) begin
            stl = (stall_at >= 0) && (rel >= stall_at) && (rel < stall_at + stall_len);
            cycle(rel == reassert_at, rel == abort_at, stl);
`ifdef COLPAR_CTRL_STALL_EN
            if (stall_len > 0 && rel == stall_at) lane_before = int'(c25);
            if (stall_len > 0 && rel == stall_at + stall_len) chk("lane_hold", int'(c25), lane_before);
`endif
        end
    endtask

    // Scoreboard monitor: per-cycle output vector, done timing and per-job strobe counts.
    initial begin
        logic [9:0] e;
        logic [9:0] a;
        int n_ldfr, n_ldr, n_en64, n_enfw, n_en25, n_init;
        n_ldfr = 0; n_ldr = 0; n_en64 = 0; n_enfw = 0; n_en25 = 0; n_init = 0;
        forever begin
            @(negedge clk);
            #1;
            a = {ld_fr, ld_r, en_fw, init0_c64, init0_c25, en_c64, en_c25, ready, busy, done};
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL out_vec cycle=%0d got=%b expected=%b", cur_cyc, a, e);
                end
            end
            if (init0_c64 === 1'b1) begin
                n_ldfr = 0; n_ldr = 0; n_en64 = 0; n_enfw = 0; n_en25 = 0; n_init = 1;
            end else begin
                n_ldfr += int'(ld_fr === 1'b1);
                n_ldr  += int'(ld_r === 1'b1);
                n_en64 += int'(en_c64 === 1'b1);
                n_enfw += int'(en_fw === 1'b1);
                n_en25 += int'(en_c25 === 1'b1);
            end
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("done_cycle", cur_cyc, done_q.pop_front());
                end
                chk("cnt_ld_fr", n_ldfr, DEPTHS);
                chk("cnt_ld_r", n_ldr, DEPTHS);
                chk("cnt_en_c64", n_en64, DEPTHS);
                chk("cnt_en_fw", n_enfw, DEPTHS * LANES);
                chk("cnt_en_c25", n_en25, DEPTHS * LANES);
                chk("cnt_init0", n_init, 1);
            end
        end
    end

    // Stimulus sequence.
    initial begin
        int c0;
        int k, j, len;
        // Reset, then a quiet idle stretch.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);

        // Job with start re-asserted mid-job and a 10-cycle stall inside CALC of depth 10.
        run_job(500, -1, 3 + 10 * PER_D + 5, 10, 2);

        // Job aborted by reset at cycle 800: no done pulse may follow.
        run_job(-1, 800, -1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);

        // start held high: two back-to-back jobs separated by one IDLE cycle.
        cycle(1'b1, 1'b0, 1'b0);
        c0 = cur_cyc;
        done_q.push_back(c0 + DONE_T);
        done_q.push_back(c0 + DONE_T + 1 + DONE_T);
        for (int rel = 1; rel <= 2 * DONE_T + 4; rel++) cycle(rel <= DONE_T + 1, 1'b0, 1'b0);

        // Randomized jobs: random idle gaps (stall toggling there must be inert),
        // random mid-job re-start and a random stall window starting inside CALC.
        for (int n = 0; n < 3; n++) begin
            for (int g = 0; g < int'($urandom_range(0, 5)); g++)
                cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            k   = int'($urandom_range(0, DEPTHS - 1));
            j   = int'($urandom_range(0, LANES - 1));
            len = int'($urandom_range(1, 10));
            run_job(int'($urandom_range(2, 1700)), -1, 3 + k * PER_D + j, len, 1);
        end

        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        chk("done_q_drained", done_q.size(), 0);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
